// File: rtl/teclado_digitos_pkg.sv
// Shared types for the keypad front end: packed password entry, key codes
// and the row/column to key decode.
package teclado_digitos_pkg;

  localparam int NUM_DIGITOS = 20;
  localparam logic [3:0] DIGITO_VAZIO = 4'hF;

  typedef logic [NUM_DIGITOS-1:0][3:0] senhaPac_t;

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, T8, T9, T_AST, T_HASH
  } tecla_t;

  localparam senhaPac_t SENHA_VAZIA = {NUM_DIGITOS{DIGITO_VAZIO}};

  // Rows 0..2 hold digits 1..9 in reading order; row 3 is "* 0 #".
  function automatic tecla_t decode_tecla(input logic [1:0] row, input logic [1:0] col);
    tecla_t t;
    t = T0;
    if (row != 2'd3) begin
      t = tecla_t'(4'(row) * 4'd3 + 4'(col) + 4'd1);
    end else begin
      case (col)
        2'd0:    t = T_AST;
        2'd2:    t = T_HASH;
        default: t = T0;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/teclado_digitos_varredura.sv
// Column scan and press/release debounce for a 4x3 matrix keypad.
//   state       | meaning
//   S_SCAN      | rotating column drive, rows sampled on last dwell cycle
//   S_DEB_PRESS | column held, counting cycles rows match the latched pattern
//   S_WAIT_REL  | column held, counting consecutive all-zero row cycles
module teclado_varredura
  import teclado_digitos_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [2:0] cols,
  output tecla_t     tecla,
  output logic       tecla_ok
);

  localparam int SW = $clog2(SCAN_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_SCAN      = 2'd0;
  localparam logic [1:0] S_DEB_PRESS = 2'd1;
  localparam logic [1:0] S_WAIT_REL  = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] dwell_cnt;
  logic [DW-1:0] deb_cnt;
  logic [3:0]    row_lat;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;

  always_comb begin
    row_idx = 2'd3;
    case (row_lat)
      4'b0001: row_idx = 2'd0;
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase
  end

  always_comb begin
    col_idx = 2'd0;
    case (cols)
      3'b010:  col_idx = 2'd1;
      3'b100:  col_idx = 2'd2;
      default: col_idx = 2'd0;
    endcase
  end

  // Combinational so the top's registered pulse lands one edge after the
  // cycle in which the press count completes.
  assign tecla    = decode_tecla(row_idx, col_idx);
  assign tecla_ok = (state == S_DEB_PRESS) && (rows == row_lat) && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SCAN;
      cols      <= 3'b001;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      row_lat   <= '0;
    end else begin
      case (state)
        S_SCAN: begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if ($onehot(rows)) begin
              row_lat <= rows;
              deb_cnt <= '0;
              state   <= S_DEB_PRESS;
            end else begin
              cols <= {cols[1:0], cols[2]};
            end
          end else begin
            dwell_cnt <= dwell_cnt + SW'(1);
          end
        end
        S_DEB_PRESS: begin
          if (rows != row_lat) begin
            state <= S_SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            state   <= S_WAIT_REL;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        S_WAIT_REL: begin
          if (rows != 4'b0000) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt   <= '0;
            dwell_cnt <= '0;
            cols      <= {cols[1:0], cols[2]};
            state     <= S_SCAN;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: state <= S_SCAN;
      endcase
    end
  end

endmodule

// File: rtl/teclado_digitos.sv
// Keypad front end: accumulates debounced digits into a packed entry and
// presents it with a one-cycle valid pulse on '#'.
module teclado_digitos
  import teclado_digitos_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [2:0] cols,
  output senhaPac_t  digitos_value,
  output logic       digitos_valid,
  output logic       tecla_pulse
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  tecla_t        tecla;
  logic          tecla_ok;
  senhaPac_t     buffer;
  logic [4:0]    count;
  logic [TW-1:0] to_cnt;

  teclado_varredura #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_varredura (
    .clk     (clk),
    .rst     (rst),
    .rows    (rows),
    .cols    (cols),
    .tecla   (tecla),
    .tecla_ok(tecla_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer        <= SENHA_VAZIA;
      count         <= '0;
      to_cnt        <= '0;
      digitos_value <= SENHA_VAZIA;
      digitos_valid <= 1'b0;
      tecla_pulse   <= 1'b0;
    end else begin
      digitos_valid <= 1'b0;
      tecla_pulse   <= tecla_ok;
      // An accepted key takes priority over an expiring timeout.
      if (tecla_ok) begin
        to_cnt <= TO_LOAD;
        case (tecla)
          T_AST: begin
            buffer <= SENHA_VAZIA;
            count  <= '0;
          end
          T_HASH: begin
            if (count != 5'd0) begin
              digitos_value <= buffer;
              digitos_valid <= 1'b1;
              buffer        <= SENHA_VAZIA;
              count         <= '0;
            end
          end
          default: begin
            if (count < 5'(NUM_DIGITOS)) begin
              buffer <= {buffer[NUM_DIGITOS-2:0], 4'(tecla)};
              count  <= count + 5'd1;
            end
          end
        endcase
      end else if (count != 5'd0) begin
        if (to_cnt == '0) begin
          buffer <= SENHA_VAZIA;
          count  <= '0;
        end else begin
          to_cnt <= to_cnt - TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_teclado_digitos.sv
// Self-checking bench for teclado_digitos: keypad model, directed table,
// multi-cycle corner sequences and randomized key entry against a queue model.
module tb_teclado_digitos;
  import teclado_digitos_pkg::*;

  localparam int SC = 4;
  localparam int DB = 3;
  localparam int TO = 50;
  localparam int LONG_GAP = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rows;
  logic [2:0] cols;
  senhaPac_t  digitos_value;
  logic       digitos_valid;
  logic       tecla_pulse;

  always #5 clk = ~clk;

  teclado_digitos #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rows         (rows),
    .cols         (cols),
    .digitos_value(digitos_value),
    .digitos_valid(digitos_valid),
    .tecla_pulse  (tecla_pulse)
  );

  // Physical keypad: a pressed key connects its row to its column.
  logic       key_down = 1'b0;
  int         key_row = 0;
  int         key_col = 0;
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_rows = 4'b0000;

  always_comb begin
    rows = 4'b0000;
    if (ovr_en) rows = ovr_rows;
    else if (key_down && cols[key_col]) rows = 4'b0001 << key_row;
  end

  int n_chk = 0;
  int n_fail = 0;
  int n_pulse = 0;
  int n_valid = 0;
  logic prev_pulse = 1'b0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (tecla_pulse) n_pulse++;
    if (digitos_valid) n_valid++;
    if (tecla_pulse || digitos_valid) begin
      n_chk++;
      if ((tecla_pulse && prev_pulse) || (digitos_valid && prev_valid) || (digitos_valid && !tecla_pulse)) begin
        n_fail++;
        $display("FAIL pulse_shape: pulse=%b prev_pulse=%b valid=%b prev_valid=%b, required single isolated pulses",
                 tecla_pulse, prev_pulse, digitos_valid, prev_valid);
      end
    end
    prev_pulse = tecla_pulse;
    prev_valid = digitos_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: typed digits oldest first, last presented entry, event counts.
  int        m_dig[$];
  int        m_pulses = 0;
  int        m_valids = 0;
  senhaPac_t m_value = '1;

  function automatic senhaPac_t pack_model();
    senhaPac_t v;
    v = '1;
    for (int i = 0; i < m_dig.size(); i++) v[i] = 4'(m_dig[m_dig.size() - 1 - i]);
    return v;
  endfunction

  task automatic model_key(input int k);
    m_pulses++;
    if (k <= 9) begin
      if (m_dig.size() < NUM_DIGITOS) m_dig.push_back(k);
    end else if (k == 10) begin
      m_dig.delete();
    end else if (m_dig.size() > 0) begin
      m_value = pack_model();
      m_valids++;
      m_dig.delete();
    end
  endtask

  task automatic set_key(input int k);
    if (k == 0) begin
      key_row = 3; key_col = 1;
    end else if (k <= 9) begin
      key_row = (k - 1) / 3; key_col = (k - 1) % 3;
    end else if (k == 10) begin
      key_row = 3; key_col = 0;
    end else begin
      key_row = 3; key_col = 2;
    end
  endtask

  task automatic wait_cols(input logic [2:0] target);
    int t;
    t = 0;
    while (cols !== target && t < 100) begin
      tick(1);
      t++;
    end
    if (cols !== target) chk("wait_cols", 80'(cols), 80'(target));
  endtask

  // k: 0..9 digit, 10 '*', 11 '#'. Holds until acceptance, then hold more,
  // optional release bounce, then idle gap. A long gap implies a timeout.
  task automatic press(input int k, input int hold, input int gap, input bit bounce, input bit lat);
    int  t;
    bit  seen;
    set_key(k);
    if (lat) begin
      wait_cols(3'b100);
      wait_cols(3'b001);
    end
    key_down = 1'b1;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 200) begin
      tick(1);
      t++;
      seen = tecla_pulse;
    end
    chk("key_accepted", 80'(seen), 80'(1));
    if (lat) chk("press_latency", 80'(t), 80'(SC - 1 + DB + 1));
    model_key(k);
    tick(hold);
    if (bounce) begin
      repeat (3) begin
        key_down = 1'b0; tick(1);
        key_down = 1'b1; tick(1);
      end
    end
    key_down = 1'b0;
    tick(gap);
    if (gap >= LONG_GAP) m_dig.delete();
    chk("pulse_count", 80'(n_pulse), 80'(m_pulses));
    chk("valid_count", 80'(n_valid), 80'(m_valids));
    chk("digitos_value", digitos_value, m_value);
  endtask

  typedef struct {
    int        key;
    int        gap;
    bit        exp_valid;
    senhaPac_t exp_value;
  } vec_t;

  initial begin
    vec_t      vec[12];
    senhaPac_t v_empty, v_1234, v_f7, v_20;
    int        base_p, base_v;
    bit        saw_col2;

    v_empty = '1;
    v_1234  = 80'hFFFF_FFFF_FFFF_FFFF_1234;
    v_f7    = 80'hFFFF_FFFF_FFFF_FFFF_FFF7;
    v_20    = 80'h0123_4567_8901_2345_6789;

    vec[0]  = '{1,  5, 1'b0, v_empty};
    vec[1]  = '{2,  5, 1'b0, v_empty};
    vec[2]  = '{3,  5, 1'b0, v_empty};
    vec[3]  = '{4,  5, 1'b0, v_empty};
    vec[4]  = '{11, 5, 1'b1, v_1234};
    vec[5]  = '{5,  5, 1'b0, v_1234};
    vec[6]  = '{6,  5, 1'b0, v_1234};
    vec[7]  = '{10, 5, 1'b0, v_1234};
    vec[8]  = '{7,  5, 1'b0, v_1234};
    vec[9]  = '{11, 5, 1'b1, v_f7};
    vec[10] = '{9,  LONG_GAP, 1'b0, v_f7};
    vec[11] = '{11, 5, 1'b0, v_f7};

    rst = 1'b1;
    tick(3);
    chk("reset_cols", 80'(cols), 80'(3'b001));
    chk("reset_value", digitos_value, v_empty);
    chk("reset_valid", 80'(digitos_valid), 80'(0));
    chk("reset_pulse", 80'(tecla_pulse), 80'(0));
    rst = 1'b0;
    tick(2);

    // Exact press latency from a column-aligned press, then clear.
    press(1, 2, 5, 1'b0, 1'b1);
    press(10, 2, 5, 1'b0, 1'b0);

    // Scenarios 1, 3, 4 from a table.
    for (int i = 0; i < 12; i++) begin
      base_v = n_valid;
      press(vec[i].key, 2, vec[i].gap, 1'b0, 1'b0);
      chk("table_valid", 80'(n_valid - base_v), 80'(vec[i].exp_valid));
      chk("table_value", digitos_value, vec[i].exp_value);
    end

    // Two-cycle glitch on r1 across the col1 sample point.
    base_p = n_pulse;
    wait_cols(3'b001);
    wait_cols(3'b010);
    tick(SC - 1);
    ovr_rows = 4'b0010;
    ovr_en = 1'b1;
    tick(2);
    ovr_en = 1'b0;
    saw_col2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (cols == 3'b100) saw_col2 = 1'b1;
    end
    chk("glitch_no_pulse", 80'(n_pulse - base_p), 80'(0));
    chk("glitch_scan_resumes", 80'(saw_col2), 80'(1));

    // Long hold with release bounce: one acceptance only.
    base_p = n_pulse;
    press(5, 25, 6, 1'b1, 1'b0);
    chk("hold_single_accept", 80'(n_pulse - base_p), 80'(1));
    press(10, 2, 5, 1'b0, 1'b0);

    // 21 digits then '#': the 21st is dropped but still beeps.
    base_p = n_pulse;
    for (int i = 0; i < 21; i++) press(i % 10, 1, 5, 1'b0, 1'b0);
    press(11, 2, 5, 1'b0, 1'b0);
    chk("overflow_value", digitos_value, v_20);
    chk("overflow_pulses", 80'(n_pulse - base_p), 80'(22));

    // Two rows high together is never a key.
    base_p = n_pulse;
    ovr_rows = 4'b0011;
    ovr_en = 1'b1;
    tick(30);
    ovr_en = 1'b0;
    tick(5);
    chk("multirow_ignored", 80'(n_pulse - base_p), 80'(0));

    // Reset mid-entry drops the partial entry.
    press(1, 2, 5, 1'b0, 1'b0);
    press(2, 2, 5, 1'b0, 1'b0);
    press(3, 2, 5, 1'b0, 1'b0);
    rst = 1'b1;
    tick(2);
    chk("rst_cols", 80'(cols), 80'(3'b001));
    chk("rst_value", digitos_value, v_empty);
    chk("rst_valid", 80'(digitos_valid), 80'(0));
    chk("rst_pulse", 80'(tecla_pulse), 80'(0));
    rst = 1'b0;
    m_dig.delete();
    m_value = '1;
    tick(2);
    base_v = n_valid;
    press(11, 2, 5, 1'b0, 1'b0);
    chk("rst_hash_no_valid", 80'(n_valid - base_v), 80'(0));

    // Randomized entry against the model.
    for (int i = 0; i < 40; i++) begin
      int r, k, g;
      r = int'($urandom_range(0, 15));
      if (r <= 11) k = r % 10;
      else if (r <= 13) k = 11;
      else k = 10;
      g = ($urandom_range(0, 9) == 0) ? LONG_GAP : int'($urandom_range(5, 8));
      press(k, int'($urandom_range(1, 5)), g, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
